// File: rtl/mu0_arb_pkg.sv
// Shared types and default widths for the MU0 memory-port arbiter.
package mu0_arb_pkg;

   localparam int MU0_ADDR_W = 12;
   localparam int MU0_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GNT_CORE = 2'd1,
      GNT_DBG  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mu0_mem_arbiter_if.sv
// Bundle of the core, debug and memory ports around the arbiter.
// The slave view belongs to the arbiter; the master view belongs to its surroundings.
interface mu0_mem_arbiter_if
   import mu0_arb_pkg::*;
#(
   parameter int ADDR_W = MU0_ADDR_W,
   parameter int DATA_W = MU0_DATA_W
);

   logic              Core_Rd;
   logic              Core_Wr;
   logic [ADDR_W-1:0] Core_Addr;
   logic [DATA_W-1:0] Core_DOut;
   logic [DATA_W-1:0] Core_DIn;
   logic              Core_Ready;

   logic              Dbg_Rd;
   logic              Dbg_Wr;
   logic [ADDR_W-1:0] Dbg_Addr;
   logic [DATA_W-1:0] Dbg_DOut;
   logic [DATA_W-1:0] Dbg_DIn;
   logic              Dbg_Ready;

   logic              Mem_Rd;
   logic              Mem_Wr;
   logic [ADDR_W-1:0] Mem_Addr;
   logic [DATA_W-1:0] Mem_DOut;
   logic [DATA_W-1:0] Mem_DIn;
   logic              Mem_Ack;

   logic              Grant_Dbg;
   logic              Bus_Err;

   modport slave (
      input  Core_Rd, Core_Wr, Core_Addr, Core_DOut,
      output Core_DIn, Core_Ready,
      input  Dbg_Rd, Dbg_Wr, Dbg_Addr, Dbg_DOut,
      output Dbg_DIn, Dbg_Ready,
      output Mem_Rd, Mem_Wr, Mem_Addr, Mem_DOut,
      input  Mem_DIn, Mem_Ack,
      output Grant_Dbg, Bus_Err
   );

   modport master (
      output Core_Rd, Core_Wr, Core_Addr, Core_DOut,
      input  Core_DIn, Core_Ready,
      output Dbg_Rd, Dbg_Wr, Dbg_Addr, Dbg_DOut,
      input  Dbg_DIn, Dbg_Ready,
      input  Mem_Rd, Mem_Wr, Mem_Addr, Mem_DOut,
      output Mem_DIn, Mem_Ack,
      input  Grant_Dbg, Bus_Err
   );

endinterface

// File: rtl/mu0_wait_timer.sv
// Counts cycles spent in a grant state; expired flags the abort point.
module mu0_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] r_cnt;

   assign expired = (r_cnt == CNT_W'(MAX_WAIT));

   // Saturates at MAX_WAIT so a stale count never wraps back below the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en && !expired) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Per-transaction arbiter sharing the MU0 memory port between the core and a
// debug/loader port, with wait-state acknowledge and bounded-wait abort.
module mu0_mem_arbiter
   import mu0_arb_pkg::*;
#(
   parameter int ADDR_W   = MU0_ADDR_W,
   parameter int DATA_W   = MU0_DATA_W,
   parameter int MAX_WAIT = 15
) (
   input  logic             Clk,
   input  logic             Reset,
   mu0_mem_arbiter_if.slave bus
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_last_dbg;
   logic              r_grant_dbg;
   logic              r_bus_err;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_dout;
   logic [DATA_W-1:0] r_core_din;
   logic [DATA_W-1:0] r_dbg_din;

   logic              w_core_pend;
   logic              w_dbg_pend;
   logic              w_pick_dbg;
   logic              w_start;
   logic              w_in_gnt;
   logic              w_done;
   logic              w_abort;
   logic              w_expired;
   logic              w_sel_wr;
   logic              w_sel_rd;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_dout;

   mu0_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_timer (
      .clk     (Clk),
      .rst     (Reset),
      .clr     (w_start),
      .en      (w_in_gnt && !w_done),
      .expired (w_expired)
   );

   always_comb begin
      w_core_pend = bus.Core_Rd || bus.Core_Wr;
      w_dbg_pend  = bus.Dbg_Rd  || bus.Dbg_Wr;
      // On a tie the port not served last wins.
      w_pick_dbg  = w_dbg_pend && (!w_core_pend || !r_last_dbg);
      w_start     = (r_state == IDLE) && (w_core_pend || w_dbg_pend);
      w_in_gnt    = (r_state == GNT_CORE) || (r_state == GNT_DBG);
      w_done      = w_in_gnt && (bus.Mem_Ack || w_expired);
      w_abort     = w_in_gnt && !bus.Mem_Ack && w_expired;

      w_sel_wr    = w_pick_dbg ? bus.Dbg_Wr   : bus.Core_Wr;
      w_sel_rd    = (w_pick_dbg ? bus.Dbg_Rd  : bus.Core_Rd) && !w_sel_wr;
      w_sel_addr  = w_pick_dbg ? bus.Dbg_Addr : bus.Core_Addr;
      w_sel_dout  = w_pick_dbg ? bus.Dbg_DOut : bus.Core_DOut;

      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_start) w_state_nxt = w_pick_dbg ? GNT_DBG : GNT_CORE;
         GNT_CORE,
         GNT_DBG:  if (w_done)  w_state_nxt = IDLE;
         default:               w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_last_dbg  <= 1'b1;
         r_grant_dbg <= 1'b0;
         r_bus_err   <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_dout  <= '0;
         r_core_din  <= '0;
         r_dbg_din   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant_dbg <= (w_state_nxt == GNT_DBG);
         if (w_start) begin
            r_last_dbg <= w_pick_dbg;
            r_mem_rd   <= w_sel_rd;
            r_mem_wr   <= w_sel_wr;
            r_mem_addr <= w_sel_addr;
            r_mem_dout <= w_sel_dout;
         end else if (w_done) begin
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
         end
         if (w_abort) r_bus_err <= 1'b1;
         // Read data is captured only on an acknowledged read, never on abort.
         if (bus.Mem_Ack && r_mem_rd && (r_state == GNT_CORE)) r_core_din <= bus.Mem_DIn;
         if (bus.Mem_Ack && r_mem_rd && (r_state == GNT_DBG))  r_dbg_din  <= bus.Mem_DIn;
      end
   end

   assign bus.Core_Ready = w_done && (r_state == GNT_CORE);
   assign bus.Dbg_Ready  = w_done && (r_state == GNT_DBG);
   assign bus.Core_DIn   = r_core_din;
   assign bus.Dbg_DIn    = r_dbg_din;
   assign bus.Mem_Rd     = r_mem_rd;
   assign bus.Mem_Wr     = r_mem_wr;
   assign bus.Mem_Addr   = r_mem_addr;
   assign bus.Mem_DOut   = r_mem_dout;
   assign bus.Grant_Dbg  = r_grant_dbg;
   assign bus.Bus_Err    = r_bus_err;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Scoreboard bench for mu0_mem_arbiter: port drivers push expected outcomes,
// a monitor pops them on each Ready, a wait-state memory model answers the bus.
module tb_mu0_mem_arbiter;

   typedef struct {
      logic [15:0] din;
      bit          abort;
   } exp_t;

   logic clk;
   logic rst;

   mu0_mem_arbiter_if bus ();

   mu0_mem_arbiter #(
      .MAX_WAIT (4)
   ) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_fails  = 0;
   exp_t        sb_core[$];
   exp_t        sb_dbg[$];
   bit          grants[$];
   logic [15:0] mem     [4096];
   logic [15:0] ref_mem [4096];
   logic [15:0] ref_core_din;
   logic [15:0] ref_dbg_din;
   int          fixed_delay = -1;
   bit          no_ack      = 0;
   bit          idle_noise  = 0;
   int          tx_len      = 0;
   int          lat_c;
   int          lat_d;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one transaction on a port, record its expected outcome, wait for Ready.
   task automatic do_req(input bit dbg, input bit wr, input logic [11:0] addr,
                         input logic [15:0] wdata, input bit abort, output int lat);
      exp_t e;
      bit   rd_too;
      rd_too = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (dbg) begin
         bus.Dbg_Rd = rd_too; bus.Dbg_Wr = wr; bus.Dbg_Addr = addr; bus.Dbg_DOut = wdata;
      end else begin
         bus.Core_Rd = rd_too; bus.Core_Wr = wr; bus.Core_Addr = addr; bus.Core_DOut = wdata;
      end
      e.abort = abort;
      if (dbg) begin
         e.din = (!abort && !wr) ? ref_mem[addr] : ref_dbg_din;
         ref_dbg_din = e.din;
         sb_dbg.push_back(e);
      end else begin
         e.din = (!abort && !wr) ? ref_mem[addr] : ref_core_din;
         ref_core_din = e.din;
         sb_core.push_back(e);
      end
      if (wr && !abort) ref_mem[addr] = wdata;
      lat = -1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (dbg ? bus.Dbg_Ready : bus.Core_Ready) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) begin
         n_checks++;
         n_fails++;
         $display("FAIL ready_timeout: port %0d got no Ready within 60 cycles, expected one", dbg);
      end
      @(posedge clk); #1;
      if (dbg) begin bus.Dbg_Rd = 1'b0; bus.Dbg_Wr = 1'b0; end
      else     begin bus.Core_Rd = 1'b0; bus.Core_Wr = 1'b0; end
   endtask

   // Memory model with random or fixed wait states.
   initial begin : responder
      bit          active = 0;
      int          cnt = 0;
      int          dly = 0;
      bit          ack;
      logic [11:0] a0;
      logic [15:0] d0;
      logic        rd0, wr0, g0;
      bus.Mem_Ack = 1'b0;
      bus.Mem_DIn = '0;
      forever begin
         @(posedge clk); #1;
         if (bus.Mem_Rd || bus.Mem_Wr) begin
            if (!active) begin
               active = 1; cnt = 0;
               dly = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
               a0 = bus.Mem_Addr; d0 = bus.Mem_DOut; rd0 = bus.Mem_Rd; wr0 = bus.Mem_Wr;
               g0 = bus.Grant_Dbg;
               grants.push_back(g0);
            end else begin
               cnt++;
               check("mem_addr_stable", {20'd0, bus.Mem_Addr}, {20'd0, a0});
               check("mem_dout_stable", {16'd0, bus.Mem_DOut}, {16'd0, d0});
               check("mem_strobes_stable", {30'd0, bus.Mem_Rd, bus.Mem_Wr}, {30'd0, rd0, wr0});
               check("grant_stable", {31'd0, bus.Grant_Dbg}, {31'd0, g0});
            end
            tx_len = cnt + 1;
            ack = !no_ack && (cnt == dly);
            bus.Mem_Ack = ack;
            bus.Mem_DIn = (ack && bus.Mem_Rd) ? mem[bus.Mem_Addr] : 16'($urandom);
            if (ack && bus.Mem_Wr) mem[bus.Mem_Addr] = bus.Mem_DOut;
         end else begin
            active = 0;
            bus.Mem_Ack = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.Mem_DIn = 16'($urandom);
         end
      end
   end

   // Monitor: pops the expected outcome on each Ready, checks data one cycle later.
   initial begin : monitor
      exp_t ce, de;
      bit   cpend = 0, dpend = 0;
      bit   exp_bus_err = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_bus_err = 0; cpend = 0; dpend = 0;
         end else begin
            if (cpend) begin
               check("core_din", {16'd0, bus.Core_DIn}, {16'd0, ce.din});
               check("bus_err_core", {31'd0, bus.Bus_Err}, {31'd0, exp_bus_err});
               cpend = 0;
            end
            if (dpend) begin
               check("dbg_din", {16'd0, bus.Dbg_DIn}, {16'd0, de.din});
               check("bus_err_dbg", {31'd0, bus.Bus_Err}, {31'd0, exp_bus_err});
               dpend = 0;
            end
            if (bus.Core_Ready || bus.Dbg_Ready)
               check("ready_exclusive", {31'd0, bus.Core_Ready && bus.Dbg_Ready}, 32'd0);
            if (bus.Core_Ready) begin
               check("core_ready_grant", {31'd0, bus.Grant_Dbg}, 32'd0);
               if (sb_core.size() == 0) begin
                  check("core_unexpected_ready", 32'd1, 32'd0);
               end else begin
                  ce = sb_core.pop_front();
                  if (ce.abort) exp_bus_err = 1;
                  cpend = 1;
               end
            end
            if (bus.Dbg_Ready) begin
               check("dbg_ready_grant", {31'd0, bus.Grant_Dbg}, 32'd1);
               if (sb_dbg.size() == 0) begin
                  check("dbg_unexpected_ready", 32'd1, 32'd0);
               end else begin
                  de = sb_dbg.pop_front();
                  if (de.abort) exp_bus_err = 1;
                  dpend = 1;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); #1 rst = 1'b0;
      ref_core_din = '0;
      ref_dbg_din  = '0;
   endtask

   initial begin : main
      rst = 1'b1;
      bus.Core_Rd = 0; bus.Core_Wr = 0; bus.Core_Addr = '0; bus.Core_DOut = '0;
      bus.Dbg_Rd  = 0; bus.Dbg_Wr  = 0; bus.Dbg_Addr  = '0; bus.Dbg_DOut  = '0;
      ref_core_din = '0;
      ref_dbg_din  = '0;
      for (int i = 0; i < 4096; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[12'h010]     = 16'h1234;
      ref_mem[12'h010] = 16'h1234;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_rd",    {31'd0, bus.Mem_Rd},     32'd0);
      check("rst_mem_wr",    {31'd0, bus.Mem_Wr},     32'd0);
      check("rst_mem_addr",  {20'd0, bus.Mem_Addr},   32'd0);
      check("rst_mem_dout",  {16'd0, bus.Mem_DOut},   32'd0);
      check("rst_core_din",  {16'd0, bus.Core_DIn},   32'd0);
      check("rst_dbg_din",   {16'd0, bus.Dbg_DIn},    32'd0);
      check("rst_bus_err",   {31'd0, bus.Bus_Err},    32'd0);
      check("rst_grant_dbg", {31'd0, bus.Grant_Dbg},  32'd0);
      check("rst_readies",   {30'd0, bus.Core_Ready, bus.Dbg_Ready}, 32'd0);
      #1 rst = 1'b0;

      // Core read, ack on the first strobe cycle.
      fixed_delay = 0;
      do_req(0, 0, 12'h010, 16'h0, 0, lat_c);
      check("core_read_latency", lat_c, 32'd1);

      // Debug write with three wait states, then read it back.
      fixed_delay = 3;
      do_req(1, 1, 12'h0FF, 16'hBEEF, 0, lat_d);
      check("dbg_write_latency", lat_d, 32'd4);
      check("dbg_write_strobe_cycles", tx_len, 32'd4);
      check("dbg_write_grant", {31'd0, grants[$]}, 32'd1);
      do_req(1, 0, 12'h0FF, 16'h0, 0, lat_d);
      check("dbg_readback_latency", lat_d, 32'd4);

      // Simultaneous requests after reset: core, debug, core, debug.
      pulse_reset();
      fixed_delay = -1;
      grants.delete();
      fork
         begin
            do_req(0, 0, 12'h010, 16'h0, 0, lat_c);
            do_req(0, 1, 12'h011, 16'h5A5A, 0, lat_c);
         end
         begin
            do_req(1, 0, 12'h0FF, 16'h0, 0, lat_d);
            do_req(1, 1, 12'h801, 16'hA5A5, 0, lat_d);
         end
      join
      check("alt_grant_count", grants.size(), 32'd4);
      for (int i = 0; i < 4 && i < grants.size(); i++)
         check("alt_grant_order", {31'd0, grants[i]}, 32'(i % 2));

      // Timeout: no ack, abort after MAX_WAIT, data kept, sticky error.
      fixed_delay = 0;
      do_req(0, 0, 12'h010, 16'h0, 0, lat_c);
      no_ack = 1;
      do_req(0, 0, 12'h005, 16'h0, 1, lat_c);
      check("timeout_latency", lat_c, 32'd5);
      no_ack = 0;
      fixed_delay = -1;
      do_req(1, 0, 12'h805, 16'h0, 0, lat_d);
      do_req(0, 0, 12'h006, 16'h0, 0, lat_c);

      // Randomized traffic on disjoint address windows, noisy ack while idle.
      idle_noise = 1;
      fork
         for (int i = 0; i < 25; i++)
            do_req(0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                   16'($urandom), 0, lat_c);
         for (int j = 0; j < 25; j++)
            do_req(1, 1'($urandom_range(0, 1)), 12'(12'h800 + $urandom_range(0, 15)),
                   16'($urandom), 0, lat_d);
      join
      idle_noise = 0;

      // Reset in the middle of a core grant.
      no_ack = 1;
      @(posedge clk); #1;
      bus.Core_Rd = 1'b1; bus.Core_Addr = 12'h020;
      @(negedge clk);
      @(negedge clk);
      check("midrst_strobe_before", {31'd0, bus.Mem_Rd}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_strobe_cleared", {31'd0, bus.Mem_Rd},     32'd0);
      check("midrst_no_ready",       {31'd0, bus.Core_Ready}, 32'd0);
      check("midrst_bus_err",        {31'd0, bus.Bus_Err},    32'd0);
      bus.Core_Rd = 1'b0;
      @(negedge clk); #1 rst = 1'b0;
      ref_core_din = '0;
      ref_dbg_din  = '0;
      no_ack = 0;
      grants.delete();
      fork
         do_req(0, 0, 12'h003, 16'h0, 0, lat_c);
         do_req(1, 0, 12'h803, 16'h0, 0, lat_d);
      join
      check("midrst_tie_count", grants.size(), 32'd2);
      if (grants.size() > 0)
         check("midrst_tie_core_first", {31'd0, grants[0]}, 32'd0);

      repeat (3) @(posedge clk);
      check("sb_core_drained", sb_core.size(), 32'd0);
      check("sb_dbg_drained",  sb_dbg.size(),  32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
